// File: rtl/hw_stack_if.sv
// rtl/hw_stack_if.sv - PSH/POP stack interface bundle between decoder and hw_stack
//
// Purpose: groups the stack command, data and status signals so the decoder
// (master) and the LIFO (slave) share one connection.
// Signals:
//   clear        master->slave  sync clear of stack and sticky flags
//   push_enable  master->slave  push request this cycle
//   push_data    master->slave  WIDTH-bit data to push
//   pop_enable   master->slave  pop request this cycle
//   pop_data     slave->master  current top of stack (combinational)
//   count        slave->master  number of valid entries, 0..DEPTH
//   empty        slave->master  count == 0
//   full         slave->master  count == DEPTH
//   overflow     slave->master  sticky: push rejected while full
//   underflow    slave->master  sticky: pop rejected while empty
interface hw_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH + 1);

  logic             clear;
  logic             push_enable;
  logic [WIDTH-1:0] push_data;
  logic             pop_enable;
  logic [WIDTH-1:0] pop_data;
  logic [AW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push_enable, push_data, pop_enable,
    input  pop_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  clear, push_enable, push_data, pop_enable,
    output pop_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - hardware LIFO serving the decoder PSH/POP stack interface
//
// Purpose: DEPTH x WIDTH stack. Pushes write on the rising edge; the top of
// stack is presented combinationally so a pop can route it in the same cycle,
// and the entry is removed at the edge. Sticky overflow/underflow flags record
// rejected operations until clear or reset.
// Ports:
//   clk_i    in  system clock, rising edge
//   rst_n_i  in  asynchronous active-low reset
//   bus      hw_stack_if.slave (clear, push/pop requests, data and status)
module hw_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  hw_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [IW-1:0] top_idx;
  logic          empty;
  logic          full;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == AW'(DEPTH));
  // Index of the top entry; meaningless when empty, which pop_data masks.
  assign top_idx = IW'(sp_q - AW'(1));

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = IW'(sp_q);
    if (bus.clear) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      case ({bus.push_enable, bus.pop_enable})
        2'b10: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = IW'(sp_q);
            sp_d    = sp_q + AW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            sp_d = sp_q - AW'(1);
          end
        end
        2'b11: begin
          if (empty) begin
            // Pop half is rejected, push half still lands in slot 0.
            wr_en   = 1'b1;
            wr_addr = '0;
            sp_d    = AW'(1);
            unf_d   = 1'b1;
          end else begin
            // Replace the top in place; valid even when full since sp is unchanged.
            wr_en   = 1'b1;
            wr_addr = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately not reset; only entries below sp are ever read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.push_data;
    end
  end

  assign bus.pop_data  = empty ? '0 : mem_q[top_idx];
  assign bus.count     = sp_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_hw_stack.sv
// tb/tb_hw_stack.sv - directed self-checking bench for hw_stack
module tb_hw_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hw_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic clr, input logic pu, input logic po, input logic [WIDTH-1:0] d);
    bus.clear       = clr;
    bus.push_enable = pu;
    bus.pop_enable  = po;
    bus.push_data   = d;
    #1;
  endtask

  // Advance one edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.clear       = 1'b0;
    bus.push_enable = 1'b0;
    bus.pop_enable  = 1'b0;
    bus.push_data   = '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    set_in(1'b0, 1'b1, 1'b0, d);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.clear       = 1'b0;
    bus.push_enable = 1'b0;
    bus.pop_enable  = 1'b0;
    bus.push_data   = '0;
    #22;
    rst_n = 1'b1;
    tick();

    // 1. reset / idle
    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_pop_data", 32'(bus.pop_data), 0);
    check_eq("rst_ovf", 32'(bus.overflow), 0);
    check_eq("rst_unf", 32'(bus.underflow), 0);

    // 2. push three, pop three in LIFO order
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check_eq("p3_count", 32'(bus.count), 3);
    set_in(1'b0, 1'b0, 1'b1, '0);
    check_eq("pop1_data", 32'(bus.pop_data), 32'h33);
    tick();
    set_in(1'b0, 1'b0, 1'b1, '0);
    check_eq("pop2_data", 32'(bus.pop_data), 32'h22);
    tick();
    set_in(1'b0, 1'b0, 1'b1, '0);
    check_eq("pop3_data", 32'(bus.pop_data), 32'h11);
    tick();
    check_eq("pop_empty", 32'(bus.empty), 1);
    check_eq("pop_unf", 32'(bus.underflow), 0);
    check_eq("pop_count", 32'(bus.count), 0);

    // 3. fill, then overflow
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check_eq("fill_full", 32'(bus.full), 1);
    check_eq("fill_count", 32'(bus.count), 16);
    check_eq("fill_ovf", 32'(bus.overflow), 0);
    push(8'hAA);
    check_eq("ovf_flag", 32'(bus.overflow), 1);
    check_eq("ovf_count", 32'(bus.count), 16);
    check_eq("ovf_top", 32'(bus.pop_data), 32'h0F);
    check_eq("ovf_full", 32'(bus.full), 1);

    // 4. clear, underflow, clear again
    set_in(1'b1, 1'b0, 1'b0, '0);
    tick();
    check_eq("clr_count", 32'(bus.count), 0);
    check_eq("clr_ovf", 32'(bus.overflow), 0);
    set_in(1'b0, 1'b0, 1'b1, '0);
    tick();
    check_eq("unf_flag", 32'(bus.underflow), 1);
    check_eq("unf_count", 32'(bus.count), 0);
    check_eq("unf_pop_data", 32'(bus.pop_data), 0);
    set_in(1'b1, 1'b0, 1'b0, '0);
    tick();
    check_eq("clr2_unf", 32'(bus.underflow), 0);
    check_eq("clr2_ovf", 32'(bus.overflow), 0);

    // 5. simultaneous push+pop
    push(8'h05);
    push(8'h07);
    set_in(1'b0, 1'b1, 1'b1, 8'h99);
    check_eq("pp_old_top", 32'(bus.pop_data), 32'h07);
    tick();
    check_eq("pp_new_top", 32'(bus.pop_data), 32'h99);
    check_eq("pp_count", 32'(bus.count), 2);
    set_in(1'b0, 1'b0, 1'b1, '0);
    tick();
    check_eq("pp_below", 32'(bus.pop_data), 32'h05);
    set_in(1'b0, 1'b0, 1'b1, '0);
    tick();
    check_eq("pp_drained", 32'(bus.empty), 1);
    set_in(1'b0, 1'b1, 1'b1, 8'h44);
    check_eq("ppe_pop_data", 32'(bus.pop_data), 0);
    tick();
    check_eq("ppe_count", 32'(bus.count), 1);
    check_eq("ppe_top", 32'(bus.pop_data), 32'h44);
    check_eq("ppe_unf", 32'(bus.underflow), 1);
    // clear outranks a push in the same cycle
    set_in(1'b1, 1'b1, 1'b0, 8'h55);
    tick();
    check_eq("clr_prio_count", 32'(bus.count), 0);
    check_eq("clr_prio_unf", 32'(bus.underflow), 0);

    // 6. asynchronous reset between edges
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    check_eq("pre_rst_count", 32'(bus.count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(bus.count), 0);
    check_eq("arst_pop_data", 32'(bus.pop_data), 0);
    check_eq("arst_empty", 32'(bus.empty), 1);
    #3;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_count", 32'(bus.count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
